// File: rtl/ysyx_22050612_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff and redirect.
// master = fetch unit, slave = the environment (memory, decode and execute).
interface ysyx_22050612_ifu_if #(
    parameter int ADDR_W = 64
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_resp_valid;
    logic [31:0]       imem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch: one outstanding imem read, result held for decode until consumed.
// Best case one instruction per 3 cycles; decode backpressure holds the word and blocks new requests.
module ysyx_22050612_ifu #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000,
    parameter int                CNT_W    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ysyx_22050612_ifu_if.master     bus,
    output logic [CNT_W-1:0]        fetch_cnt
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q;
    logic [ADDR_W-1:0] redirect_tgt;

    assign redirect_tgt = bus.redirect_pc & ~ADDR_W'(3);

    // run_q keeps the request line low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            inst_q    <= NOP;
            inst_pc_q <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
            run_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_REQ: begin
                if (run_q && bus.imem_req_ready) begin
                    state_d = S_WAIT;
                    // accepted request still carries the old pc; its data must be thrown away
                    if (bus.redirect_valid) begin
                        pc_d   = redirect_tgt;
                        drop_d = 1'b1;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end
            S_WAIT: begin
                if (bus.imem_resp_valid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (bus.redirect_valid) begin
                        pc_d = redirect_tgt;
                    end else if (!drop_q) begin
                        state_d   = S_HOLD;
                        inst_d    = bus.imem_resp_data;
                        inst_pc_d = pc_q;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d   = redirect_tgt;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    state_d = S_REQ;
                    pc_d    = redirect_tgt;
                end else if (bus.inst_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + ADDR_W'(4);
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign bus.imem_req_valid = (state_q == S_REQ) && run_q;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = (state_q == S_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign fetch_cnt          = cnt_q;
endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Bench for the fetch unit: directed vector table, corner sequences, then random traffic
// checked against a transaction-level model of the expected instruction stream.
module tb_ysyx_22050612_ifu;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] fetch_cnt;

    ysyx_22050612_ifu_if #(.ADDR_W(64)) bus ();

    ysyx_22050612_ifu #(.ADDR_W(64), .RESET_PC(RST_PC), .CNT_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rr, rv;
        logic [31:0] rd;
        logic        ir, xv;
        logic [63:0] xpc;
        logic        e_rq;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
        logic [63:0] e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                         input logic ir, input logic xv, input logic [63:0] xpc);
        bus.imem_req_ready  = rr;
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = rd;
        bus.inst_ready      = ir;
        bus.redirect_valid  = xv;
        bus.redirect_pc     = xpc;
    endtask

    task automatic check_outs(input string tag, input logic rq, input logic [63:0] addr,
                              input logic iv, input logic [31:0] ins,
                              input logic [63:0] ipc, input logic [63:0] cnt);
        check({tag, ".req_valid"}, 64'(bus.imem_req_valid), 64'(rq));
        check({tag, ".addr"},      bus.imem_addr, addr);
        check({tag, ".inst_valid"}, 64'(bus.inst_valid), 64'(iv));
        check({tag, ".inst"},      64'(bus.inst), 64'(ins));
        check({tag, ".inst_pc"},   bus.inst_pc, ipc);
        check({tag, ".fetch_cnt"}, fetch_cnt, cnt);
    endtask

    function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                                input logic ir, input logic xv, input logic [63:0] xpc,
                                input logic e_rq, input logic [63:0] e_addr, input logic e_iv,
                                input logic [31:0] e_inst, input logic [63:0] e_ipc,
                                input logic [63:0] e_cnt);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.xv = xv; v.xpc = xpc;
        v.e_rq = e_rq; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] D1  = 32'h0010_0093;
    localparam logic [31:0] D2  = 32'h0020_0113;
    localparam logic [31:0] D3  = 32'h0030_0193;
    localparam logic [31:0] D4  = 32'h0040_0213;
    localparam logic [31:0] D5  = 32'h0050_0293;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    vec_t vt[20];

    // random-phase model state
    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    logic [63:0] p_addr;
    logic        pending;
    int          p_delay;
    int          delivered;

    initial begin
        // row: inputs for this cycle | outputs expected before this cycle's edge
        vt[0]  = mk(1,0,0,  0,0,0,             1, RST_PC,      0, NOP, 0,           0);
        vt[1]  = mk(0,1,D1, 0,0,0,             0, RST_PC,      0, NOP, 0,           0);
        vt[2]  = mk(0,0,0,  1,0,0,             0, RST_PC,      1, D1,  RST_PC,      0);
        vt[3]  = mk(1,0,0,  0,0,0,             1, RST_PC+4,    0, D1,  RST_PC,      1);
        vt[4]  = mk(0,1,D2, 0,0,0,             0, RST_PC+4,    0, D1,  RST_PC,      1);
        for (int i = 5; i < 10; i++)
            vt[i] = mk(0,0,0, 0,0,0,           0, RST_PC+4,    1, D2,  RST_PC+4,    1);
        vt[10] = mk(0,0,0,  1,0,0,             0, RST_PC+4,    1, D2,  RST_PC+4,    1);
        vt[11] = mk(1,0,0,  0,0,0,             1, RST_PC+8,    0, D2,  RST_PC+4,    2);
        vt[12] = mk(0,0,0,  0,1,64'h8000_1002, 0, RST_PC+8,    0, D2,  RST_PC+4,    2);
        vt[13] = mk(0,1,BAD,0,0,0,             0, 64'h8000_1000, 0, D2, RST_PC+4,   2);
        vt[14] = mk(1,0,0,  0,0,0,             1, 64'h8000_1000, 0, D2, RST_PC+4,   2);
        vt[15] = mk(0,1,BAD,0,1,64'h8000_2000, 0, 64'h8000_1000, 0, D2, RST_PC+4,   2);
        vt[16] = mk(1,0,0,  0,0,0,             1, 64'h8000_2000, 0, D2, RST_PC+4,   2);
        vt[17] = mk(0,1,D3, 0,0,0,             0, 64'h8000_2000, 0, D2, RST_PC+4,   2);
        vt[18] = mk(0,0,0,  1,1,64'h8000_0200, 0, 64'h8000_2000, 1, D3, 64'h8000_2000, 2);
        vt[19] = mk(0,0,0,  0,0,0,             1, 64'h8000_0200, 0, D3, 64'h8000_2000, 2);

        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_outs("reset", 0, RST_PC, 0, NOP, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vt[i].e_rq, vt[i].e_addr, vt[i].e_iv,
                       vt[i].e_inst, vt[i].e_ipc, vt[i].e_cnt);
            drive(vt[i].rr, vt[i].rv, vt[i].rd, vt[i].ir, vt[i].xv, vt[i].xpc);
        end

        // stalled request, then redirect together with acceptance
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_outs($sformatf("stall%0d", k), 1, 64'h8000_0200, 0, D3, 64'h8000_2000, 2);
            drive(0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 64'h8000_0400);
        @(negedge clk);
        check_outs("redir_acc.wait", 0, 64'h8000_0400, 0, D3, 64'h8000_2000, 2);
        drive(0, 1, BAD, 0, 0, 0);
        @(negedge clk);
        check_outs("redir_acc.req", 1, 64'h8000_0400, 0, D3, 64'h8000_2000, 2);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, D4, 0, 0, 0);
        @(negedge clk);
        check_outs("redir_acc.hold", 0, 64'h8000_0400, 1, D4, 64'h8000_0400, 2);
        drive(0, 0, 0, 1, 0, 0);

        // pc wrap at the top of the address space
        @(negedge clk);
        check_outs("seq.next", 1, 64'h8000_0404, 0, D4, 64'h8000_0400, 3);
        drive(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("wrap.addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, D5, 0, 0, 0);
        @(negedge clk);
        check_outs("wrap.hold", 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, D5, 64'hFFFF_FFFF_FFFF_FFFC, 3);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_outs("wrap.next", 1, 64'h0, 0, D5, 64'hFFFF_FFFF_FFFF_FFFC, 4);
        drive(0, 1, BAD, 0, 0, 0);
        @(negedge clk);
        check_outs("stray_resp", 1, 64'h0, 0, D5, 64'hFFFF_FFFF_FFFF_FFFC, 4);
        drive(1, 0, 0, 0, 0, 0);

        // asynchronous reset while a response is outstanding
        @(negedge clk);
        check("rst_wait.req_valid", 64'(bus.imem_req_valid), 64'h0);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_outs("rst_async", 0, RST_PC, 0, NOP, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, BAD, 0, 0, 0);
        #1 check("rst_release.req_valid", 64'(bus.imem_req_valid), 64'h0);
        @(negedge clk);
        check_outs("rst_late_resp", 1, RST_PC, 0, NOP, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // random traffic against the stream model
        m_pc = RST_PC; m_cnt = 0; pending = 1'b0; p_delay = 0; p_addr = 0; delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        rq, iv, rr, rv, ir, xv;
            logic [31:0] rd;
            logic [63:0] xpc;
            @(negedge clk);
            check("rnd.fetch_cnt", fetch_cnt, m_cnt);
            rq  = bus.imem_req_valid;
            iv  = bus.inst_valid;
            rr  = ($urandom % 10) < 6;
            ir  = ($urandom % 10) < 6;
            xv  = ($urandom % 100) < 8;
            xpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            rv  = 1'b0;
            rd  = $urandom;
            if (pending) begin
                check("rnd.req_while_outstanding", 64'(rq), 64'h0);
                if (p_delay == 0) begin
                    rv = 1'b1;
                    rd = mem_word(p_addr);
                    pending = 1'b0;
                end else begin
                    p_delay--;
                end
            end else if (!(rq && rr) && ($urandom % 20) == 0) begin
                rv = 1'b1;
            end
            drive(rr, rv, rd, ir, xv, xpc);

            if (rq && rr) begin
                check("rnd.req_addr", bus.imem_addr, m_pc);
                pending = 1'b1;
                p_delay = $urandom % 3;
                p_addr  = bus.imem_addr;
            end
            if (iv && ir && !xv) begin
                check("rnd.inst_pc", bus.inst_pc, m_pc);
                check("rnd.inst", 64'(bus.inst), 64'(mem_word(m_pc)));
                m_pc = m_pc + 64'd4;
                m_cnt++;
                delivered++;
            end
            if (xv) m_pc = xpc & ~64'd3;
        end
        check("rnd.progress", 64'(delivered > 50), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22050612_ifu.md
Name: ysyx_22050612_ifu

Overview:
Instruction fetch unit for the single-issue RV64 core.
- Owns the PC and issues one 32-bit instruction read at a time to the instruction memory port.
- Hands each fetched word, with its PC, to the decode stage over a valid/ready handshake.
- Accepts PC redirects from execute (branches/jumps) and squashes any in-flight or held fetch made on the wrong path.

Parameters:
ADDR_W, 64, PC / fetch address width
RESET_PC, 64'h8000_0000, PC value after reset
CNT_W, 64, width of retired-fetch counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  ADDR_W  fetch address, bits [1:0] always 0
imem_resp_valid  in  1  read data valid (one-cycle pulse per accepted request)
imem_resp_data  in  32  instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction this cycle
inst  out  32  instruction word to decode
inst_pc  out  ADDR_W  PC of inst
redirect_valid  in  1  execute requests PC change
redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (forced 0)
fetch_cnt  out  CNT_W  count of instructions handed to decode

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=REQ, pc=RESET_PC, drop=0, inst=32'h0000_0013 (nop), inst_pc=0, fetch_cnt=0.
  - imem_req_valid is 0 while rst_n is low and 1 from the first clk edge after release.
- State machine has three states: REQ, WAIT, HOLD. Only one memory request is ever outstanding.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready: go to WAIT.
  - Redirect with no ready: pc<=redirect_pc, stay in REQ. imem_addr changes next cycle; a request that is not yet accepted may change.
  - Redirect and imem_req_ready in the same cycle: the accepted request carries the old pc. Set pc<=redirect_pc, drop<=1, go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with drop=0 and no redirect: inst<=data, inst_pc<=pc, go to HOLD.
  - On imem_resp_valid with drop=1: discard data, drop<=0, go to REQ.
  - Redirect with no response: pc<=redirect_pc, drop<=1, stay in WAIT.
  - Redirect and response in the same cycle: discard data, pc<=redirect_pc, drop<=0, go to REQ.
- HOLD:
  - inst_valid=1; inst and inst_pc held stable until consumed.
  - On inst_ready (no redirect): pc<=pc+4 (modulo 2^ADDR_W, wraps), fetch_cnt<=fetch_cnt+1 (wraps), go to REQ.
  - Redirect (with or without inst_ready): the held instruction is squashed. No count increment, pc<=redirect_pc, go to REQ. Redirect wins over inst_ready.
- inst_valid is 1 only in HOLD. It never depends combinationally on inst_ready.
- Throughput: a 0-wait memory with immediate response gives REQ→WAIT→HOLD, i.e. at best one instruction every 3 cycles. This is acceptable for the multi-cycle core.
- imem_resp_valid in REQ or HOLD is a protocol error: ignore it, with no state change.
- Reset asserted mid-operation (any state, including WAIT): return to reset values immediately. A late response arriving after release is ignored as a protocol error (state REQ).

Test Plan:
- Reset, then memory ready=1 with a 1-cycle response of 32'h00100093, decode ready=1 → imem_addr=0x80000000; inst_valid rises in cycle 3 with inst=00100093 and inst_pc=0x80000000; next imem_addr=0x80000004; fetch_cnt=1.
- Decode ready held 0 for 5 cycles in HOLD → inst/inst_pc stable; imem_req_valid=0 throughout; fetch_cnt unchanged until ready is seen.
- Redirect to 0x80001002 in WAIT, before the response → the response is discarded (no inst_valid); next request has imem_addr=0x80001000.
- Redirect asserted in the same cycle as the response → data discarded; next cycle REQ with the redirect address; no inst_valid.
- Redirect to 0x80000200 in HOLD, in the same cycle as inst_ready → fetch_cnt does not increment; next imem_addr=0x80000200.
- Request stalled (ready=0) for 4 cycles, then redirect and ready in the same cycle → response for the old address is dropped; the following request is for the redirect_pc. Also: assert rst_n low while in WAIT → outputs at reset values asynchronously; pc=RESET_PC after release.
